// File: rtl/logic_gate_pkg.sv
// Shared types and constants for the registered bitwise gate unit and its truth-table sweep.
package logic_gate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int SWEEP_LEN = 28;
  // Bit op*4+{a,b}; BUF (op 7) lies beyond the 28 swept entries.
  localparam logic [SWEEP_LEN-1:0] EXPECTED_TT = 28'h96173E8;

endpackage

// File: rtl/logic_gate_core.sv
// Combinational WIDTH-bit bitwise gate; NOT and BUF pass/invert operand a only.
module logic_gate_core
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (op_e'(i_op))
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_NOT:  o_y = ~i_a;
      OP_NAND: o_y = ~(i_a & i_b);
      OP_NOR:  o_y = ~(i_a | i_b);
      OP_XOR:  o_y = i_a ^ i_b;
      OP_XNOR: o_y = ~(i_a ^ i_b);
      OP_BUF:  o_y = i_a;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered bitwise gate with valid/ready handshake and a built-in truth-table sweep.
// state | meaning: IDLE accept operands | DRAIN wait for output empty | SWEEP walk 28 vectors | DONE one-cycle done pulse
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     y,
  input  logic                 sweep_start,
  output logic                 sweep_busy,
  output logic                 sweep_done,
  output logic [SWEEP_LEN-1:0] sweep_tt,
  output logic                 sweep_err
);

  localparam logic [4:0] LAST_IDX = 5'(SWEEP_LEN - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_y;
  logic [4:0]           r_cnt;
  logic [SWEEP_LEN-1:0] r_tt;
  logic                 r_err;

  logic                 w_xfer;
  logic [WIDTH-1:0]     w_dp_y;
  logic [WIDTH-1:0]     w_sw_a;
  logic [WIDTH-1:0]     w_sw_b;
  logic [WIDTH-1:0]     w_sw_y;
  logic                 w_sw_nonuniform;

  assign in_ready = !rst && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_xfer   = in_valid && in_ready;

  logic_gate_core #(.WIDTH(WIDTH)) u_core_dp (
    .i_op (op),
    .i_a  (a),
    .i_b  (b),
    .o_y  (w_dp_y)
  );

  assign w_sw_a = {WIDTH{r_cnt[1]}};
  assign w_sw_b = {WIDTH{r_cnt[0]}};

  logic_gate_core #(.WIDTH(WIDTH)) u_core_sweep (
    .i_op (r_cnt[4:2]),
    .i_a  (w_sw_a),
    .i_b  (w_sw_b),
    .o_y  (w_sw_y)
  );

  // Any bit disagreeing with the others means a lane is broken.
  assign w_sw_nonuniform = (w_sw_y != '0) && (w_sw_y != '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_y         <= w_dp_y;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        // An operand accepted alongside the start must drain before sweeping.
        if (sweep_start) w_state_nxt = (r_out_valid || w_xfer) ? ST_DRAIN : ST_SWEEP;
      end
      ST_DRAIN: if (!r_out_valid) w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (r_cnt == LAST_IDX) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_tt  <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (sweep_start) begin
            r_tt  <= '0;
            r_err <= 1'b0;
          end
        end
        ST_SWEEP: begin
          r_tt[r_cnt] <= w_sw_y[0];
          r_err       <= r_err | w_sw_nonuniform;
          r_cnt       <= (r_cnt == LAST_IDX) ? 5'd0 : r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign y          = r_y;
  assign sweep_busy = (r_state == ST_DRAIN) || (r_state == ST_SWEEP);
  assign sweep_done = (r_state == ST_DONE);
  assign sweep_tt   = r_tt;
  assign sweep_err  = r_err;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit: op table, backpressure, and sweep corner cases.
module tb_logic_gate_unit;
  import logic_gate_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         sweep_start;
  logic         sweep_busy;
  logic         sweep_done;
  logic [27:0]  sweep_tt;
  logic         sweep_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y           (y),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .sweep_tt    (sweep_tt),
    .sweep_err   (sweep_err)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until sweep_done is seen, bounded so a dead FSM cannot hang the run.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (sweep_done !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    bit saw_done;

    vecs[0]  = '{3'd0, 8'hC3, 8'hA5, 8'h81};
    vecs[1]  = '{3'd1, 8'hC3, 8'hA5, 8'hE7};
    vecs[2]  = '{3'd2, 8'hC3, 8'hA5, 8'h3C};
    vecs[3]  = '{3'd3, 8'hC3, 8'hA5, 8'h7E};
    vecs[4]  = '{3'd4, 8'hC3, 8'hA5, 8'h18};
    vecs[5]  = '{3'd5, 8'hC3, 8'hA5, 8'h66};
    vecs[6]  = '{3'd6, 8'hC3, 8'hA5, 8'h99};
    vecs[7]  = '{3'd7, 8'hC3, 8'hA5, 8'hC3};
    vecs[8]  = '{3'd0, 8'hFF, 8'h00, 8'h00};
    vecs[9]  = '{3'd1, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{3'd2, 8'h00, 8'hFF, 8'hFF};
    vecs[11] = '{3'd7, 8'h5A, 8'hFF, 8'h5A};

    rst = 1'b1; in_valid = 1'b1; a = 8'h12; b = 8'h34; op = 3'd0;
    out_ready = 1'b1; sweep_start = 1'b0;

    // Reset
    #1;
    chk("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y", {24'd0, y}, 32'd0);
    chk("rst_tt", {4'd0, sweep_tt}, 32'd0);
    chk("rst_done", {31'd0, sweep_done}, 32'd0);
    chk("rst_err", {31'd0, sweep_err}, 32'd0);
    chk("rst_ready_held", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Op table at full throughput
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      #1;
      chk($sformatf("ready_v%0d", i), {31'd0, in_ready}, 32'd1);
      step();
      chk($sformatf("y_v%0d", i), {24'd0, y}, {24'd0, vecs[i].y});
      chk($sformatf("ov_v%0d", i), {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("drain_ov", {31'd0, out_valid}, 32'd0);
    chk("drain_y_hold", {24'd0, y}, 32'h5A);

    // Backpressure
    in_valid = 1'b1; op = 3'd5; a = 8'hFF; b = 8'h0F;
    step();
    chk("bp_first_y", {24'd0, y}, 32'hF0);
    out_ready = 1'b0; op = 3'd0; a = 8'hAA; b = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_ready_%0d", i), {31'd0, in_ready}, 32'd0);
      step();
      chk($sformatf("bp_y_%0d", i), {24'd0, y}, 32'hF0);
      chk($sformatf("bp_ov_%0d", i), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_next_y", {24'd0, y}, 32'hAA);
    chk("bp_next_ov", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Sweep from an empty pipe: busy cycles 1..28, done in cycle 29
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    saw_done = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      if (sweep_busy !== 1'b1 || in_ready !== 1'b0) saw_done = 1'b1;
      if (sweep_done !== 1'b0) saw_done = 1'b1;
      if (k < 28) step();
      else begin
        chk("sw1_busy_window", {31'd0, saw_done}, 32'd0);
        step();
      end
    end
    chk("sw1_done", {31'd0, sweep_done}, 32'd1);
    chk("sw1_busy_off", {31'd0, sweep_busy}, 32'd0);
    chk("sw1_tt", {4'd0, sweep_tt}, {4'd0, EXPECTED_TT});
    chk("sw1_err", {31'd0, sweep_err}, 32'd0);
    chk("sw1_ready_done", {31'd0, in_ready}, 32'd0);
    step();
    chk("sw1_done_pulse", {31'd0, sweep_done}, 32'd0);
    chk("sw1_ready_back", {31'd0, in_ready}, 32'd1);
    chk("sw1_tt_hold", {4'd0, sweep_tt}, {4'd0, EXPECTED_TT});

    // Sweep with a full pipe goes through DRAIN
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; a = 8'h5A; b = 8'hFF;
    step();
    in_valid = 1'b0;
    chk("fp_y", {24'd0, y}, 32'h5A);
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    chk("fp_tt_cleared", {4'd0, sweep_tt}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fp_drain_busy_%0d", i), {31'd0, sweep_busy}, 32'd1);
      chk($sformatf("fp_drain_y_%0d", i), {24'd0, y}, 32'h5A);
      chk($sformatf("fp_drain_ov_%0d", i), {31'd0, out_valid}, 32'd1);
      if (i < 2) step();
    end
    out_ready = 1'b1;
    step();
    chk("fp_ov_fell", {31'd0, out_valid}, 32'd0);
    chk("fp_still_busy", {31'd0, sweep_busy}, 32'd1);
    wait_done(cyc);
    chk("fp_done_latency", cyc, 32'd29);
    chk("fp_tt", {4'd0, sweep_tt}, {4'd0, EXPECTED_TT});
    chk("fp_err", {31'd0, sweep_err}, 32'd0);
    step();

    // Operand and sweep_start together: transfer completes, then drain, then sweep
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd1; a = 8'h0F; b = 8'hF0;
    sweep_start = 1'b1;
    #1;
    chk("both_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; sweep_start = 1'b0;
    chk("both_y", {24'd0, y}, 32'hFF);
    chk("both_busy", {31'd0, sweep_busy}, 32'd1);
    out_ready = 1'b1;
    wait_done(cyc);
    chk("both_done_latency", cyc, 32'd30);
    chk("both_tt", {4'd0, sweep_tt}, {4'd0, EXPECTED_TT});
    step();

    // Reset at sweep cycle 10
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int k = 1; k < 10; k++) step();
    chk("mid_busy", {31'd0, sweep_busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_tt", {4'd0, sweep_tt}, 32'd0);
    chk("mid_rst_busy", {31'd0, sweep_busy}, 32'd0);
    chk("mid_rst_done", {31'd0, sweep_done}, 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (sweep_done === 1'b1) saw_done = 1'b1;
    end
    chk("mid_no_done", {31'd0, saw_done}, 32'd0);
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    wait_done(cyc);
    chk("fresh_done_latency", cyc, 32'd28);
    chk("fresh_tt", {4'd0, sweep_tt}, {4'd0, EXPECTED_TT});
    chk("fresh_err", {31'd0, sweep_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
